// File: rtl/sigma_delta_ef_mod.sv
// Error-feedback sigma-delta modulator: 1st/2nd-order noise shaping with a truncating
// quantiser, optional LFSR dither, saturating or wrapping loop value and an overload flag.
module sigma_delta_ef_mod #(
    parameter int ORDER      = 2,
    parameter int IS_LIMITED = 1,
    parameter int DITHER     = 0,
    parameter int IN_WIDTH   = 16,
    parameter int OUT_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [IN_WIDTH-1:0]  in,
    output logic [OUT_WIDTH-1:0] sdOut,
    output logic                 overload
);

    localparam int S  = IN_WIDTH - OUT_WIDTH;
    localparam int VW = IN_WIDTH + 3;

    localparam logic signed [VW-1:0]  V_MAX    = VW'(2**(IN_WIDTH-1) - 1);
    localparam logic signed [VW-1:0]  V_MIN    = ~V_MAX;
    localparam logic [IN_WIDTH-1:0]   IN_MAX   = {1'b0, {(IN_WIDTH-1){1'b1}}};
    localparam logic [IN_WIDTH-1:0]   IN_MIN   = {1'b1, {(IN_WIDTH-1){1'b0}}};
    localparam logic [OUT_WIDTH-1:0]  MIDSCALE = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    generate
        if (OUT_WIDTH >= IN_WIDTH || OUT_WIDTH < 1) begin : g_bad_width
            $error("sigma_delta_ef_mod: OUT_WIDTH must be in 1..IN_WIDTH-1");
        end
        if (ORDER != 1 && ORDER != 2) begin : g_bad_order
            $error("sigma_delta_ef_mod: ORDER must be 1 or 2");
        end
    endgenerate

    logic [S-1:0]           e1_reg;
    logic [S-1:0]           e2_reg;
    logic [15:0]            lfsr_reg;
    logic                   lfsr_fb;

    logic signed [VW-1:0]   in_ext;
    logic signed [VW-1:0]   e1_ext;
    logic signed [VW-1:0]   e2_ext;
    logic signed [VW-1:0]   d_ext;
    logic signed [VW-1:0]   v_next;
    logic                   ovf_next;
    logic [IN_WIDTH-1:0]    vq_next;
    logic [OUT_WIDTH-1:0]   q_next;
    logic [S-1:0]           e_next;

    assign in_ext = {{3{in[IN_WIDTH-1]}}, in};
    assign e1_ext = {{(VW-S){1'b0}}, e1_reg};
    assign e2_ext = {{(VW-S){1'b0}}, e2_reg};
    assign d_ext  = {{(VW-1){1'b0}}, (DITHER != 0) ? lfsr_reg[0] : 1'b0};

    // 2nd order feeds back 2*e[n-1] - e[n-2], i.e. (1 - z^-1)^2 shaping of the error
    assign v_next = in_ext + ((ORDER == 2) ? ((e1_ext <<< 1) - e2_ext) : e1_ext) + d_ext;

    assign ovf_next = (v_next > V_MAX) || (v_next < V_MIN);

    always_comb begin
        vq_next = v_next[IN_WIDTH-1:0];
        if (IS_LIMITED != 0 && ovf_next) begin
            vq_next = (v_next > V_MAX) ? IN_MAX : IN_MIN;
        end
    end

    // Error is taken after clipping, so it always stays within S unsigned bits
    assign q_next  = vq_next[IN_WIDTH-1:S];
    assign e_next  = vq_next[S-1:0];
    assign lfsr_fb = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];

    always_ff @(posedge clk) begin
        if (rst) begin
            e1_reg   <= '0;
            e2_reg   <= '0;
            lfsr_reg <= 16'hACE1;
            sdOut    <= MIDSCALE;
            overload <= 1'b0;
        end else if (en) begin
            sdOut    <= q_next ^ MIDSCALE;
            overload <= ovf_next;
            e2_reg   <= e1_reg;
            e1_reg   <= e_next;
            lfsr_reg <= {lfsr_reg[14:0], lfsr_fb};
        end
    end

endmodule

// File: tb/tb_sigma_delta_ef_mod.sv
// Bench for sigma_delta_ef_mod: four parameter variants run side by side against an
// integer reference model through a scoreboard, plus scenario-specific inline checks.
module tb_sigma_delta_ef_mod;

    // inst0: ORDER1 sat, inst1: ORDER2 sat, inst2: ORDER2 wrap, inst3: ORDER2 sat dither
    localparam int P_ORDER [4] = '{1, 2, 2, 2};
    localparam int P_LIM   [4] = '{1, 1, 0, 1};
    localparam int P_DITH  [4] = '{0, 0, 0, 1};

    typedef struct {
        int e1;
        int e2;
        int lfsr;
        int sd;
        int ov;
    } mstate_t;

    typedef struct packed {
        logic [3:0][7:0] sd;
        logic [3:0]      ov;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [15:0] in_val = '0;
    logic [15:0] in_d   = '0;
    logic [7:0]  sd [4];
    logic        ov [4];

    int      total = 0;
    int      bad   = 0;
    exp_t    sb_q[$];
    exp_t    mon_exp;
    mstate_t ms [4];

    always #5 clk = ~clk;

    sigma_delta_ef_mod #(.ORDER(1), .IS_LIMITED(1), .DITHER(0), .IN_WIDTH(16), .OUT_WIDTH(8)) u0 (
        .clk(clk), .rst(rst), .en(en), .in(in_val), .sdOut(sd[0]), .overload(ov[0]));
    sigma_delta_ef_mod #(.ORDER(2), .IS_LIMITED(1), .DITHER(0), .IN_WIDTH(16), .OUT_WIDTH(8)) u1 (
        .clk(clk), .rst(rst), .en(en), .in(in_val), .sdOut(sd[1]), .overload(ov[1]));
    sigma_delta_ef_mod #(.ORDER(2), .IS_LIMITED(0), .DITHER(0), .IN_WIDTH(16), .OUT_WIDTH(8)) u2 (
        .clk(clk), .rst(rst), .en(en), .in(in_val), .sdOut(sd[2]), .overload(ov[2]));
    sigma_delta_ef_mod #(.ORDER(2), .IS_LIMITED(1), .DITHER(1), .IN_WIDTH(16), .OUT_WIDTH(8)) u3 (
        .clk(clk), .rst(rst), .en(en), .in(in_d), .sdOut(sd[3]), .overload(ov[3]));

    function automatic mstate_t mreset();
        mstate_t s;
        s.e1 = 0; s.e2 = 0; s.lfsr = 'hACE1; s.sd = 128; s.ov = 0;
        return s;
    endfunction

    // Integer model: floor quantisation of the clipped/wrapped loop value
    function automatic mstate_t mstep(mstate_t s, int idx, int x);
        mstate_t n;
        int d, v, vw, e, fb;
        d = (P_DITH[idx] != 0) ? (s.lfsr & 1) : 0;
        if (P_ORDER[idx] == 1) v = x + s.e1 + d;
        else                   v = x + 2 * s.e1 - s.e2 + d;
        n.ov = (v > 32767 || v < -32768) ? 1 : 0;
        if (P_LIM[idx] != 0) vw = (v > 32767) ? 32767 : ((v < -32768) ? -32768 : v);
        else                 vw = (((v + 32768) % 65536) + 65536) % 65536 - 32768;
        e    = ((vw % 256) + 256) % 256;
        n.sd = (vw - e) / 256 + 128;
        n.e1 = e;
        n.e2 = s.e1;
        fb   = ((s.lfsr >> 15) ^ (s.lfsr >> 13) ^ (s.lfsr >> 12) ^ (s.lfsr >> 10)) & 1;
        n.lfsr = ((s.lfsr << 1) | fb) & 'hFFFF;
        return n;
    endfunction

    task automatic drive(input logic r, input logic e, input int x, input int xd);
        exp_t ex;
        @(negedge clk);
        rst    = r;
        en     = e;
        in_val = x[15:0];
        in_d   = xd[15:0];
        for (int i = 0; i < 4; i++) begin
            if (r)      ms[i] = mreset();
            else if (e) ms[i] = mstep(ms[i], i, (i == 3) ? xd : x);
            ex.sd[i] = 8'(ms[i].sd);
            ex.ov[i] = ms[i].ov[0];
        end
        sb_q.push_back(ex);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            mon_exp = sb_q.pop_front();
            for (int i = 0; i < 4; i++) begin
                total++;
                if (sd[i] !== mon_exp.sd[i]) begin
                    bad++;
                    $display("FAIL sb_sdout inst%0d t=%0t: got %02h expected %02h", i, $time, sd[i], mon_exp.sd[i]);
                end
                total++;
                if (ov[i] !== mon_exp.ov[i]) begin
                    bad++;
                    $display("FAIL sb_overload inst%0d t=%0t: got %0b expected %0b", i, $time, ov[i], mon_exp.ov[i]);
                end
            end
        end
    end

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 1'b0, 0, 0);
            tick();
            for (int i = 0; i < 4; i++) begin
                total++;
                if (sd[i] !== 8'h80) begin
                    bad++;
                    $display("FAIL reset_sdout inst%0d: got %02h expected 80", i, sd[i]);
                end
                total++;
                if (ov[i] !== 1'b0) begin
                    bad++;
                    $display("FAIL reset_overload inst%0d: got %0b expected 0", i, ov[i]);
                end
            end
        end
        $display("test_reset: 3 reset cycles checked");
    endtask

    task automatic test_zero();
        for (int n = 0; n < 1000; n++) begin
            drive(1'b0, 1'b1, 0, 0);
            tick();
            for (int i = 0; i < 3; i++) begin
                total++;
                if (sd[i] !== 8'h80 || ov[i] !== 1'b0) begin
                    bad++;
                    $display("FAIL zero_input inst%0d n=%0d: got %02h/%0b expected 80/0", i, n, sd[i], ov[i]);
                end
            end
        end
        $display("test_zero: 1000 zero samples");
    endtask

    task automatic test_dc();
        logic [7:0] pat1 [4];
        logic [7:0] pat2 [3];
        int sum;
        pat1 = '{8'h80, 8'h80, 8'h80, 8'h81};
        pat2 = '{8'h80, 8'h80, 8'h81};
        drive(1'b1, 1'b0, 0, 0);
        tick();
        sum = 0;
        for (int n = 0; n < 1024; n++) begin
            drive(1'b0, 1'b1, 'h40, 'h40);
            tick();
            sum += int'(sd[1]) - 128;
            if (n < 16) begin
                total++;
                if (sd[0] !== pat1[n % 4]) begin
                    bad++;
                    $display("FAIL dc_order1 n=%0d: got %02h expected %02h", n, sd[0], pat1[n % 4]);
                end
            end
            if (n < 3) begin
                total++;
                if (sd[1] !== pat2[n]) begin
                    bad++;
                    $display("FAIL dc_order2 n=%0d: got %02h expected %02h", n, sd[1], pat2[n]);
                end
            end
        end
        total++;
        if (sum < 255 || sum > 257) begin
            bad++;
            $display("FAIL dc_order2_sum: got %0d expected 256+-1", sum);
        end
        $display("test_dc: in=0x0040 order2 sum=%0d", sum);
    endtask

    task automatic test_overload();
        drive(1'b1, 1'b0, 0, 0);
        tick();
        for (int n = 0; n < 8; n++) begin
            drive(1'b0, 1'b1, 32767, 0);
            tick();
            total++;
            if (sd[1] !== 8'hFF || ov[1] !== (n > 0)) begin
                bad++;
                $display("FAIL ovl_sat n=%0d: got %02h/%0b expected ff/%0b", n, sd[1], ov[1], (n > 0));
            end
            if (n == 0) begin
                total++;
                if (sd[2] !== 8'hFF || ov[2] !== 1'b0) begin
                    bad++;
                    $display("FAIL ovl_wrap_first: got %02h/%0b expected ff/0", sd[2], ov[2]);
                end
            end
            if (n == 1) begin
                total++;
                if (sd[2] !== 8'h01 || ov[2] !== 1'b1) begin
                    bad++;
                    $display("FAIL ovl_wrap_second: got %02h/%0b expected 01/1", sd[2], ov[2]);
                end
            end
        end
        for (int n = 0; n < 3; n++) begin
            drive(1'b0, 1'b1, 0, 0);
            tick();
        end
        total++;
        if (ov[1] !== 1'b0) begin
            bad++;
            $display("FAIL ovl_recover: got %0b expected 0", ov[1]);
        end
        $display("test_overload: saturating and wrapping full-scale input");
    endtask

    task automatic test_en_gap();
        mstate_t g1, g3;
        int ref1[$];
        int ref3[$];
        int k, x, last1, last3;
        logic gap;
        g1 = mreset();
        g3 = mreset();
        for (int j = 0; j < 50; j++) begin
            x  = -20000 + j * 700;
            g1 = mstep(g1, 1, x);
            g3 = mstep(g3, 3, x);
            ref1.push_back(g1.sd);
            ref3.push_back(g3.sd);
        end
        drive(1'b1, 1'b0, 0, 0);
        tick();
        k = 0; last1 = 128; last3 = 128;
        for (int n = 0; n < 60; n++) begin
            gap = (n >= 25 && n < 35);
            if (gap) begin
                x = int'($urandom_range(65535)) - 32768;
                drive(1'b0, 1'b0, x, x);
            end else begin
                x = -20000 + k * 700;
                drive(1'b0, 1'b1, x, x);
                k++;
                last1 = ref1.pop_front();
                last3 = ref3.pop_front();
            end
            tick();
            total++;
            if (int'(sd[1]) != last1 || int'(sd[3]) != last3) begin
                bad++;
                $display("FAIL en_gap n=%0d gap=%0b: got %02h,%02h expected %02h,%02h",
                         n, gap, sd[1], sd[3], last1, last3);
            end
        end
        $display("test_en_gap: 10-cycle enable gap mid-ramp");
    endtask

    task automatic test_reset_mid();
        int x, ex;
        drive(1'b1, 1'b0, 0, 0);
        tick();
        for (int n = 0; n < 80; n++) begin
            x = int'(20000.0 * $sin(6.2831853 * n / 37.0));
            drive((n == 40), 1'b1, x, x);
            tick();
            if (n == 40) begin
                total++;
                if (sd[1] !== 8'h80 || ov[1] !== 1'b0) begin
                    bad++;
                    $display("FAIL mid_reset: got %02h/%0b expected 80/0", sd[1], ov[1]);
                end
            end
            if (n == 41) begin
                ex = (x - (((x % 256) + 256) % 256)) / 256 + 128;
                for (int i = 0; i < 3; i++) begin
                    total++;
                    if (int'(sd[i]) != ex) begin
                        bad++;
                        $display("FAIL post_reset inst%0d: got %02h expected %02h", i, sd[i], ex);
                    end
                end
            end
        end
        $display("test_reset_mid: 1-cycle reset pulse mid-sine");
    endtask

    task automatic test_ramp_dither();
        int sum, smin, smax;
        drive(1'b1, 1'b0, 0, 0);
        tick();
        sum = 0; smin = 255; smax = 0;
        for (int n = 0; n < 65536; n++) begin
            drive(1'b0, 1'b1, n - 32768, 0);
            tick();
            if (n < 65535) begin
                sum += int'(sd[3]) - 128;
                if (int'(sd[3]) < smin) smin = int'(sd[3]);
                if (int'(sd[3]) > smax) smax = int'(sd[3]);
            end
        end
        total++;
        if (sum < 126 || sum > 130) begin
            bad++;
            $display("FAIL dither_sum: got %0d expected 128+-2", sum);
        end
        total++;
        if (smin == smax) begin
            bad++;
            $display("FAIL dither_varies: got constant %02h expected varying output", smin);
        end
        $display("test_ramp_dither: full ramp, dither sum=%0d range %0d..%0d", sum, smin, smax);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) ms[i] = mreset();
        test_reset();
        test_zero();
        test_dc();
        test_overload();
        test_en_gap();
        test_reset_mid();
        test_ramp_dither();
        @(negedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
